// File: rtl/spi_reg_writer.sv
// spi_reg_writer
//   Host-side SPI master for the register peripheral. It accepts one write
//   request (address + data) over a valid/ready handshake and sends it as
//   two 8-bit frames: an address frame {1,000,addr}, then a data frame.
//   The link runs in SPI mode 0 and sends the MSB first. A gap with nCS high
//   follows each frame. A request for an address above 4 is refused with
//   a one-cycle err pulse, and the SPI pins do not move.
//
// Ports
//   clk, rst_n        system clock; asynchronous active-low reset
//   wr_valid/wr_ready request handshake (ready only while idle)
//   wr_addr, wr_data  request payload, sampled at acceptance
//   busy              transfer in progress (inverse of wr_ready)
//   done              one-cycle pulse as nCS rises after the data frame
//   err               one-cycle pulse after a refused (addr > 4) request
//   SCLK, COPI, nCS   SPI pins, all registered
module spi_reg_writer #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS
);

    localparam int HCW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int GCW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ADDR_FRAME, GAP1, DATA_FRAME, GAP2} state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] half_q, half_d;    // clk count inside one half-period
    logic [4:0]     phase_q, phase_d;  // 0 setup, odd = SCLK high, 16 = hold
    logic [GCW-1:0] gap_q, gap_d;
    logic [7:0]     addr_byte_q, addr_byte_d;
    logic [7:0]     data_byte_q, data_byte_d;
    logic           wr_ready_q, wr_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           sclk_q, sclk_d;
    logic           copi_q, copi_d;
    logic           ncs_q, ncs_d;

    logic           in_frame;
    logic [7:0]     cur_byte;

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        phase_d     = phase_q;
        gap_d       = gap_q;
        addr_byte_d = addr_byte_q;
        data_byte_d = data_byte_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_valid && wr_ready_q) begin
                    if (wr_addr > 4'd4) begin
                        err_d = 1'b1;
                    end else begin
                        addr_byte_d = {4'b1000, wr_addr};
                        data_byte_d = wr_data;
                        state_d     = ADDR_FRAME;
                        half_d      = '0;
                        phase_d     = '0;
                    end
                end
            end
            ADDR_FRAME, DATA_FRAME: begin
                if (half_q == HCW'(CLK_DIV - 1)) begin
                    half_d = '0;
                    if (phase_q == 5'd16) begin
                        state_d = (state_q == ADDR_FRAME) ? GAP1 : GAP2;
                        gap_d   = '0;
                    end else begin
                        phase_d = phase_q + 5'd1;
                    end
                end else begin
                    half_d = half_q + HCW'(1);
                end
            end
            GAP1, GAP2: begin
                if (gap_q == GCW'(GAP_CYCLES - 1)) begin
                    state_d = (state_q == GAP1) ? DATA_FRAME : IDLE;
                    half_d  = '0;
                    phase_d = '0;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are derived from the next state so they change on the same
        // edge as the state they belong to, straight out of flops.
        in_frame   = (state_d == ADDR_FRAME) || (state_d == DATA_FRAME);
        cur_byte   = (state_d == ADDR_FRAME) ? addr_byte_d : data_byte_d;
        ncs_d      = !in_frame;
        sclk_d     = in_frame && phase_d[0];
        // Bit index steps on each even phase, i.e. as SCLK falls; zero in hold.
        copi_d     = (in_frame && (phase_d < 5'd16)) ? cur_byte[3'd7 - phase_d[3:1]] : 1'b0;
        wr_ready_d = (state_d == IDLE);
        busy_d     = !wr_ready_d;
        done_d     = (state_q == DATA_FRAME) && (state_d == GAP2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            half_q      <= '0;
            phase_q     <= '0;
            gap_q       <= '0;
            addr_byte_q <= '0;
            data_byte_q <= '0;
            wr_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sclk_q      <= 1'b0;
            copi_q      <= 1'b0;
            ncs_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            phase_q     <= phase_d;
            gap_q       <= gap_d;
            addr_byte_q <= addr_byte_d;
            data_byte_q <= data_byte_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sclk_q      <= sclk_d;
            copi_q      <= copi_d;
            ncs_q       <= ncs_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign SCLK     = sclk_q;
    assign COPI     = copi_q;
    assign nCS      = ncs_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer. Two instances are used: one with the default
// timing and one with CLK_DIV=2, GAP_CYCLES=4. A timing model compares all
// pins of both instances on every cycle. An SPI receiver on instance 0
// stands in for the register peripheral so that written values can be read
// back.
module tb_spi_reg_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld  [2];
    logic [3:0] wa   [2];
    logic [7:0] wd   [2];
    logic       rdy  [2];
    logic       busy [2];
    logic       done [2];
    logic       err  [2];
    logic       sclk [2];
    logic       copi [2];
    logic       ncs  [2];

    int hh [2] = '{4, 2};
    int gg [2] = '{8, 4};

    always #5 clk = ~clk;

    spi_reg_writer #(.CLK_DIV(4), .GAP_CYCLES(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld[0]), .wr_ready(rdy[0]),
        .wr_addr(wa[0]), .wr_data(wd[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .SCLK(sclk[0]), .COPI(copi[0]), .nCS(ncs[0]));

    spi_reg_writer #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld[1]), .wr_ready(rdy[1]),
        .wr_addr(wa[1]), .wr_data(wd[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .SCLK(sclk[1]), .COPI(copi[1]), .nCS(ncs[1]));

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- timing model ----------------
    // A transaction is described by its acceptance cycle. The pin values at
    // t cycles later come from the documented timeline: frame 0 fills
    // t = 1..17H, the gap follows, frame 1 fills 17H+G+1..34H+G, the second
    // gap follows, and the writer is ready again after 34H+2G.
    bit         m_act   [2];
    int         m_start [2];
    int         m_errc  [2];
    logic [7:0] m_ab    [2];
    logic [7:0] m_db    [2];

    function automatic logic [6:0] model_pins(input int h, input int g, input bit act,
                                              input int t, input logic [7:0] ab,
                                              input logic [7:0] db, input bit e);
        logic r, b, dn, n, s, c;
        int   k;
        logic [7:0] by;
        r = 1'b1; b = 1'b0; dn = 1'b0; n = 1'b1; s = 1'b0; c = 1'b0;
        k = -1; by = 8'h00;
        if (act && t >= 1 && t <= 34*h + 2*g) begin
            r = 1'b0; b = 1'b1;
            if (t <= 17*h) begin k = t - 1; by = ab; end
            else if (t >= 17*h + g + 1 && t <= 34*h + g) begin k = t - 1 - 17*h - g; by = db; end
            dn = (t == 34*h + g + 1);
        end
        if (k >= 0) begin
            n = 1'b0;
            s = ((k / h) % 2) == 1;
            c = (k < 16*h) ? by[7 - k/(2*h)] : 1'b0;
        end
        return {r, b, dn, e, n, s, c};
    endfunction

    function automatic bit model_ready(input int d, input int c);
        return !m_act[d] || (c - m_start[d] > 34*hh[d] + 2*gg[d]);
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_start[d] = 0; m_errc[d] = -1; m_ab[d] = 0; m_db[d] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                for (int d = 0; d < 2; d++) begin m_act[d] = 0; m_errc[d] = -1; end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (model_ready(d, cyc) && vld[d] === 1'b1) begin
                        if (wa[d] <= 4) begin
                            m_act[d] = 1; m_start[d] = cyc;
                            m_ab[d] = {4'b1000, wa[d]}; m_db[d] = wd[d];
                        end else begin
                            m_errc[d] = cyc + 1;
                        end
                    end
                end
            end
            if (clk === 1'b1) cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int done_cnt [2] = '{0, 0};
    int low_run  [2] = '{0, 0};
    int lens1 [$];
    int nprint = 0;

    initial begin
        logic [6:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp_v = model_pins(hh[d], gg[d], m_act[d], cyc - m_start[d],
                                   m_ab[d], m_db[d], cyc == m_errc[d]);
                act_v = {rdy[d], busy[d], done[d], err[d], ncs[d], sclk[d], copi[d]};
                n_chk++;
                if (act_v === exp_v) n_pass++;
                else begin
                    n_fail++;
                    if (nprint < 20) begin
                        nprint++;
                        $display("FAIL pins_dut%0d cycle %0d: got %b expected %b (rdy busy done err ncs sclk copi)",
                                 d, cyc, act_v, exp_v);
                    end
                end
                if (done[d] === 1'b1) done_cnt[d]++;
                if (ncs[d] === 1'b0) low_run[d]++;
                else if (low_run[d] > 0) begin
                    if (d == 1) lens1.push_back(low_run[d]);
                    low_run[d] = 0;
                end
            end
        end
    end

    // ---------------- SPI receiver on instance 0 ----------------
    logic [7:0] sh = 8'h00;
    int         nb = 0;
    bit         have_addr = 0;
    logic [3:0] pend = 4'h0;
    logic [7:0] last_ab = 8'h00, last_db = 8'h00;
    logic [7:0] preg [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial forever begin
        @(negedge ncs[0]);
        nb = 0; sh = 8'h00;
    end

    initial forever begin
        @(posedge sclk[0]);
        if (ncs[0] === 1'b0) begin sh = {sh[6:0], copi[0]}; nb++; end
    end

    initial forever begin
        @(posedge ncs[0]);
        if (rst_n !== 1'b1) have_addr = 0;   // cut-short frame is dropped
        else begin
            chk("sclk_rises_per_frame", nb, 8);
            if (!have_addr) begin
                last_ab = sh; pend = sh[3:0]; have_addr = 1;
            end else begin
                last_db = sh; have_addr = 0;
                if (pend <= 4) preg[pend] = sh;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input int d, input logic [3:0] a, input logic [7:0] x, output int c0);
        @(negedge clk);
        vld[d] = 1'b1; wa[d] = a; wd[d] = x; c0 = cyc;
        @(posedge clk);
        #1 vld[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int c0, output int dt, output int rt);
        dt = -1; rt = -1;
        for (int i = 0; i < 600 && rt < 0; i++) begin
            @(negedge clk);
            if (done[d] === 1'b1 && dt < 0) dt = cyc - c0;
            if (dt >= 0 && rdy[d] === 1'b1) rt = cyc - c0;
        end
    endtask

    initial begin
        int c0, c2, dt, rt, et, nlow, nbusy, nd, d0;
        logic [7:0] lb [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin vld[d] = 1'b0; wa[d] = 4'h0; wd[d] = 8'h00; end
        repeat (3) @(negedge clk);
        chk("reset_pins_dut0", {rdy[0], busy[0], done[0], err[0], ncs[0], sclk[0], copi[0]}, 7'b1000100);
        chk("reset_pins_dut1", {rdy[1], busy[1], done[1], err[1], ncs[1], sclk[1], copi[1]}, 7'b1000100);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // addr 2, data 0xA5 at default timing
        do_write(0, 4'd2, 8'hA5, c0);
        wait_done(0, c0, dt, rt);
        chk("a2_done_cycle", dt, 145);
        chk("a2_ready_cycle", rt, 153);
        chk("a2_addr_frame", last_ab, 8'h82);
        chk("a2_data_frame", last_db, 8'hA5);
        chk("a2_readback", preg[2], 8'hA5);

        // refused address
        do_write(0, 4'd7, 8'h12, c0);
        et = -1; nlow = 0; nbusy = 0; nd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err[0] === 1'b1 && et < 0) et = cyc - c0;
            if (ncs[0] !== 1'b1) nlow++;
            if (busy[0] !== 1'b0 || rdy[0] !== 1'b1) nbusy++;
            if (done[0] !== 1'b0) nd++;
        end
        chk("a7_err_cycle", et, 1);
        chk("a7_ncs_low_cycles", nlow, 0);
        chk("a7_busy_cycles", nbusy, 0);
        chk("a7_done_pulses", nd, 0);

        // two writes with wr_valid held throughout
        d0 = done_cnt[0];
        @(negedge clk);
        vld[0] = 1'b1; wa[0] = 4'd0; wd[0] = 8'h3C; c0 = cyc;
        @(negedge clk);
        wa[0] = 4'd4; wd[0] = 8'hFF;
        c2 = -1;
        for (int i = 0; i < 400 && c2 < 0; i++) begin
            if (rdy[0] === 1'b1) c2 = cyc;
            else @(negedge clk);
        end
        @(posedge clk);
        #1 vld[0] = 1'b0;
        chk("queued_second_accept", c2 - c0, 153);
        chk("queued_first_readback", preg[0], 8'h3C);
        wait_done(0, c2, dt, rt);
        chk("queued_second_done", dt, 145);
        chk("queued_done_pulses", done_cnt[0] - d0, 2);
        chk("queued_second_readback", preg[4], 8'hFF);

        // reset in the middle of the address frame
        do_write(0, 4'd3, 8'h77, c0);
        while (cyc < c0 + 40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midreset_pins", {ncs[0], sclk[0], copi[0], rdy[0], busy[0]}, 5'b10010);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_write(0, 4'd1, 8'h81, c0);
        wait_done(0, c0, dt, rt);
        chk("post_reset_done", dt, 145);
        chk("post_reset_readback", preg[1], 8'h81);
        chk("aborted_write_absent", preg[3], 8'h00);

        // fast instance: H=2, GAP=4
        lens1.delete();
        do_write(1, 4'd3, 8'h5A, c0);
        wait_done(1, c0, dt, rt);
        chk("fast_done_cycle", dt, 73);
        chk("fast_ready_cycle", rt, 77);
        chk("fast_frames", lens1.size(), 2);
        if (lens1.size() >= 2) begin
            chk("fast_addr_frame_len", lens1[0], 34);
            chk("fast_data_frame_len", lens1[1], 34);
        end

        // loopback register bank fill
        for (int i = 0; i < 5; i++) begin
            do_write(0, 4'(i), lb[i], c0);
            wait_done(0, c0, dt, rt);
            chk($sformatf("loopback_reg%0d", i), preg[i], lb[i]);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
